// File: rtl/frame_tx_scheduler_pkg.sv
// Shared frame definitions for the UART frame path.
// Holds the FSM state type, the frame delimiters, the function codes used by
// the frame producers, and the LEN formula (payload bytes + 5 framing bytes).
package frame_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [7:0] FRAME_HEAD     = 8'h52;
  localparam logic [7:0] FRAME_TAIL     = 8'h9A;
  localparam logic [7:0] FUNC_USER      = 8'h01;
  localparam logic [7:0] FUNC_HEARTBEAT = 8'h02;

  // HEAD + LEN + func + payload + checksum + TAIL
  function automatic logic [7:0] frame_len(input int unsigned payload_bytes);
    return 8'(payload_bytes + 5);
  endfunction

endpackage

// File: rtl/frame_tx_scheduler_if.sv
// Bundle of the requester-side and UART-side signals of frame_tx_scheduler.
//   req/func_in/payload_in : level request plus the data to send, per requester
//   ack/done               : per-requester pulses (data latched / tail accepted)
//   tx_data/tx_valid       : byte stream towards uart_tx, tx_ready back
//   busy                   : scheduler not idle
// slave  = scheduler side, master = producers + UART side.
interface frame_tx_scheduler_if #(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned PAYLOAD_BYTES = 8
);
  logic [N_REQ-1:0]                 req;
  logic [8*N_REQ-1:0]               func_in;
  logic [8*PAYLOAD_BYTES*N_REQ-1:0] payload_in;
  logic [N_REQ-1:0]                 ack;
  logic [N_REQ-1:0]                 done;
  logic [7:0]                       tx_data;
  logic                             tx_valid;
  logic                             tx_ready;
  logic                             busy;

  modport slave (
    input  req, func_in, payload_in, tx_ready,
    output ack, done, tx_data, tx_valid, busy
  );

  modport master (
    output req, func_in, payload_in, tx_ready,
    input  ack, done, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/frame_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter.
//   req   : request vector
//   en    : commit the current winner as last_grant
//   grant : combinational one-hot winner; search starts just after last_grant
// last_grant resets to N_REQ-1 so requester 0 has first priority.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);
  localparam int unsigned LW = $clog2(N_REQ);

  logic [LW-1:0] last_grant;
  logic [LW-1:0] grant_idx;
  logic [LW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = LW'((32'(last_grant) + off) % N_REQ);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= LW'(N_REQ - 1);
    end else if (en && found) begin
      last_grant <= grant_idx;
    end
  end
endmodule

// File: rtl/frame_tx_scheduler.sv
// Shares the UART transmit byte path between N_REQ frame requesters.
// Arbitrates round-robin, latches the winner's func/payload, and sends
//   HEAD, LEN, func, payload[0..P-1], ~checksum, TAIL
// over tx_data/tx_valid/tx_ready. The checksum is the 8-bit sum of every
// other frame byte; the inverted sum is transmitted.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : frame_tx_scheduler_if.slave (requests, acks, byte stream)
// All outputs are registered.
module frame_tx_scheduler
  import frame_tx_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned PAYLOAD_BYTES = 8,
  parameter logic [7:0]  HEAD          = FRAME_HEAD,
  parameter logic [7:0]  TAIL          = FRAME_TAIL
) (
  input logic                 clk,
  input logic                 rst_n,
  frame_tx_scheduler_if.slave bus
);
  localparam int unsigned   PW            = 8 * PAYLOAD_BYTES;
  localparam int unsigned   IW            = $clog2(PAYLOAD_BYTES + 5);
  localparam logic [7:0]    LEN           = frame_len(PAYLOAD_BYTES);
  localparam logic [IW-1:0] IDX_PAY_FIRST = IW'(3);
  localparam logic [IW-1:0] IDX_PAY_LAST  = IW'(PAYLOAD_BYTES + 2);
  localparam logic [IW-1:0] IDX_CSUM      = IW'(PAYLOAD_BYTES + 3);
  localparam logic [IW-1:0] IDX_TAIL      = IW'(PAYLOAD_BYTES + 4);

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n, idx_inc;
  logic [7:0]        acc, acc_n, acc_add;
  logic [7:0]        func_q, func_n;
  logic [PW-1:0]     pay_q, pay_n;
  logic [7:0]        tx_data_q, tx_data_n, next_byte;
  logic              tx_valid_q, tx_valid_n;
  logic              busy_q;
  logic [N_REQ-1:0]  grant_q, grant_n, ack_q, ack_n, done_q, done_n;
  logic [N_REQ-1:0]  arb_grant;
  logic              arb_en;

  assign arb_en = (state == ST_IDLE) && (|bus.req);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.req),
    .en    (arb_en),
    .grant (arb_grant)
  );

  // Next byte is built from the post-handshake index and accumulator so the
  // checksum byte already includes the last payload byte.
  always_comb begin
    idx_inc = idx + IW'(1);
    acc_add = acc;
    if (idx >= IDX_PAY_FIRST && idx <= IDX_PAY_LAST) acc_add = acc + tx_data_q;
    next_byte = TAIL;
    if (idx_inc == IW'(1))       next_byte = LEN;
    else if (idx_inc == IW'(2))  next_byte = func_q;
    else if (idx_inc == IDX_CSUM) next_byte = ~acc_add;
    for (int unsigned k = 0; k < PAYLOAD_BYTES; k++) begin
      if (idx_inc == IW'(k + 3)) next_byte = pay_q[PW-8-8*k +: 8];
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    acc_n      = acc;
    func_n     = func_q;
    pay_n      = pay_q;
    grant_n    = grant_q;
    tx_data_n  = tx_data_q;
    tx_valid_n = tx_valid_q;
    ack_n      = '0;
    done_n     = '0;
    unique case (state)
      // Latching happens on the IDLE->LOAD edge so that ack is high during LOAD.
      ST_IDLE: begin
        if (|bus.req) begin
          ack_n   = arb_grant;
          grant_n = arb_grant;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
              func_n = bus.func_in[8*i +: 8];
              pay_n  = bus.payload_in[PW*i +: PW];
            end
          end
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        acc_n      = HEAD + LEN + func_q + TAIL;
        idx_n      = '0;
        tx_data_n  = HEAD;
        tx_valid_n = 1'b1;
        state_n    = ST_SEND;
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          if (idx == IDX_TAIL) begin
            tx_valid_n = 1'b0;
            tx_data_n  = '0;
            done_n     = grant_q;
            state_n    = ST_DONE;
          end else begin
            idx_n     = idx_inc;
            acc_n     = acc_add;
            tx_data_n = next_byte;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      acc        <= '0;
      func_q     <= '0;
      pay_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      idx        <= idx_n;
      acc        <= acc_n;
      func_q     <= func_n;
      pay_q      <= pay_n;
      grant_q    <= grant_n;
      ack_q      <= ack_n;
      done_q     <= done_n;
      tx_data_q  <= tx_data_n;
      tx_valid_q <= tx_valid_n;
      busy_q     <= (state_n != ST_IDLE);
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Self-checking bench for frame_tx_scheduler: expected frame bytes and done
// pulses are queued when requests are driven and consumed as the DUT emits.
module tb_frame_tx_scheduler;
  import frame_tx_scheduler_pkg::*;

  localparam int NR = 2;
  localparam int P  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;
  int last_done_cycle = -100;
  bit release_on_ack = 1'b1;
  bit scramble_on_ack = 1'b0;

  logic [7:0]    exp_q[$];
  logic [NR-1:0] exp_done_q[$];

  always @(posedge clk) cycle_no <= cycle_no + 1;

  frame_tx_scheduler_if #(.N_REQ(NR), .PAYLOAD_BYTES(P)) bus ();

  frame_tx_scheduler #(
    .N_REQ(NR), .PAYLOAD_BYTES(P), .HEAD(8'h52), .TAIL(8'h9A)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic push_frame(input logic [7:0] func, input logic [63:0] pay);
    logic [7:0] sum;
    logic [7:0] b;
    sum = 8'h52 + 8'h0D + func + 8'h9A;
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h0D);
    exp_q.push_back(func);
    for (int k = 0; k < P; k++) begin
      b = pay[63-8*k -: 8];
      sum = sum + b;
      exp_q.push_back(b);
    end
    exp_q.push_back(~sum);
    exp_q.push_back(8'h9A);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.req = '0;
    bus.tx_ready = 1'b0;
    bus.func_in = '0;
    bus.payload_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_done_q.delete();
    last_done_cycle = -100;
    release_on_ack = 1'b1;
    scramble_on_ack = 1'b0;
  endtask

  // Consumes the byte stream until n_done done pulses; raise1_at >= 0 raises
  // req[1] after that many handshakes.
  task automatic collect(input int n_done, input int budget, input bit toggle_ready,
                         input int raise1_at);
    int seen;
    int cyc;
    int hs;
    bit rdy;
    bit prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    logic [NR-1:0] ed;
    seen = 0; cyc = 0; hs = 0; rdy = 1'b1; prev_stall = 1'b0; prev_data = '0;
    while (seen < n_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != '0) begin
        if (last_done_cycle >= 0) begin
          checks++;
          if (cycle_no - last_done_cycle < 2) begin
            errors++;
            $display("FAIL idle_gap: ack %0d cycles after done, required >= 2",
                     cycle_no - last_done_cycle);
          end
        end
        for (int i = 0; i < NR; i++) begin
          if (bus.ack[i]) begin
            if (release_on_ack) bus.req[i] = 1'b0;
            if (scramble_on_ack && i == 0) begin
              bus.payload_in[63:0] = ~bus.payload_in[63:0];
              bus.func_in[7:0] = 8'hEE;
            end
          end
        end
      end
      if (bus.done != '0) begin
        checks++;
        ed = (exp_done_q.size() > 0) ? exp_done_q.pop_front() : '0;
        if (bus.done !== ed) begin
          errors++;
          $display("FAIL done: got %b, expected %b", bus.done, ed);
        end
        seen++;
        last_done_cycle = cycle_no;
      end
      if (prev_stall) begin
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h, expected valid=1 data=%h",
                   bus.tx_valid, bus.tx_data, prev_data);
        end
      end
      rdy = toggle_ready ? ~rdy : 1'b1;
      bus.tx_ready = rdy;
      prev_stall = bus.tx_valid && !rdy;
      prev_data = bus.tx_data;
      if (bus.tx_valid && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte: got %h, expected no byte", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.tx_data !== e) begin
            errors++;
            $display("FAIL byte: got %h, expected %h", bus.tx_data, e);
          end
        end
        hs++;
        if (raise1_at >= 0 && hs == raise1_at) bus.req[1] = 1'b1;
      end
    end
    checks++;
    if (seen < n_done) begin
      errors++;
      $display("FAIL timeout: saw %0d done pulses, expected %0d", seen, n_done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d bytes not sent, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 2'b01;
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.ack !== '0)      begin errors++; $display("FAIL rst_ack: got %b, expected 00", bus.ack); end
    if (bus.done !== '0)     begin errors++; $display("FAIL rst_done: got %b, expected 00", bus.done); end
    if (bus.tx_valid !== 0)  begin errors++; $display("FAIL rst_valid: got %b, expected 0", bus.tx_valid); end
    if (bus.tx_data !== '0)  begin errors++; $display("FAIL rst_data: got %h, expected 00", bus.tx_data); end
    if (bus.busy !== 0)      begin errors++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
    bus.req = '0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks += 2;
    if (bus.tx_valid !== 0) begin errors++; $display("FAIL ready_idle_valid: got %b, expected 0", bus.tx_valid); end
    if (bus.busy !== 0)     begin errors++; $display("FAIL ready_idle_busy: got %b, expected 0", bus.busy); end
  endtask

  task automatic test_single();
    reset_dut();
    bus.func_in[7:0] = FUNC_USER;
    push_frame(FUNC_USER, 64'h0);
    exp_done_q.push_back(2'b01);
    bus.req = 2'b01;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    checks += 3;
    if (bus.ack !== 2'b01)   begin errors++; $display("FAIL ack_timing: got %b, expected 01", bus.ack); end
    if (bus.tx_valid !== 0)  begin errors++; $display("FAIL load_valid: got %b, expected 0", bus.tx_valid); end
    if (bus.busy !== 1)      begin errors++; $display("FAIL load_busy: got %b, expected 1", bus.busy); end
    bus.req = '0;
    collect(1, 40, 1'b0, -1);
    @(negedge clk);
    checks += 2;
    if (bus.busy !== 0)    begin errors++; $display("FAIL post_busy: got %b, expected 0", bus.busy); end
    if (bus.done !== '0)   begin errors++; $display("FAIL post_done: got %b, expected 00", bus.done); end
  endtask

  task automatic test_stall();
    reset_dut();
    bus.func_in[7:0] = FUNC_USER;
    bus.payload_in[63:0] = 64'h0102030405060708;
    push_frame(FUNC_USER, 64'h0102030405060708);
    exp_done_q.push_back(2'b01);
    bus.req = 2'b01;
    collect(1, 80, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    reset_dut();
    release_on_ack = 1'b0;
    bus.func_in = {FUNC_HEARTBEAT, FUNC_USER};
    push_frame(FUNC_USER, 64'h0);
    push_frame(FUNC_HEARTBEAT, 64'h0);
    push_frame(FUNC_USER, 64'h0);
    exp_done_q.push_back(2'b01);
    exp_done_q.push_back(2'b10);
    exp_done_q.push_back(2'b01);
    bus.req = 2'b11;
    collect(3, 150, 1'b0, -1);
    bus.req = '0;
  endtask

  task automatic test_midframe_req();
    reset_dut();
    scramble_on_ack = 1'b1;
    bus.func_in = {FUNC_HEARTBEAT, FUNC_USER};
    bus.payload_in = {64'hA0A1A2A3A4A5A6A7, 64'h1122334455667788};
    push_frame(FUNC_USER, 64'h1122334455667788);
    push_frame(FUNC_HEARTBEAT, 64'hA0A1A2A3A4A5A6A7);
    exp_done_q.push_back(2'b01);
    exp_done_q.push_back(2'b10);
    bus.req = 2'b01;
    collect(2, 100, 1'b0, 4);
  endtask

  task automatic test_reset_midframe();
    int hs;
    bit hit;
    reset_dut();
    bus.func_in = {FUNC_HEARTBEAT, FUNC_USER};
    bus.payload_in = {64'h0F1E2D3C4B5A6978, 64'h0};
    bus.req = 2'b01;
    bus.tx_ready = 1'b1;
    hs = 0;
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      if (bus.ack[0]) bus.req[0] = 1'b0;
      if (bus.tx_valid) begin
        if (hs == 6) hit = 1'b1;
        else hs++;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_idx6: handshakes %0d, expected 6", hs);
    end
    rst_n = 1'b0;
    bus.req[1] = 1'b1;
    @(negedge clk);
    checks += 3;
    if (bus.tx_valid !== 0) begin errors++; $display("FAIL midrst_valid: got %b, expected 0", bus.tx_valid); end
    if (bus.done !== '0)    begin errors++; $display("FAIL midrst_done: got %b, expected 00", bus.done); end
    if (bus.busy !== 0)     begin errors++; $display("FAIL midrst_busy: got %b, expected 0", bus.busy); end
    rst_n = 1'b1;
    push_frame(FUNC_HEARTBEAT, 64'h0F1E2D3C4B5A6978);
    exp_done_q.push_back(2'b10);
    collect(1, 60, 1'b0, -1);
  endtask

  initial begin
    bus.req = '0;
    bus.func_in = '0;
    bus.payload_in = '0;
    bus.tx_ready = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_midframe_req();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
